i2s_tx_serializer: RTL
======================

// Module: i2s_tx_serializer
// PURPOSE
//   Upstream companion of the I2S receive stage: accepts parallel stereo sample pairs over a
//   valid/ready handshake, buffers them in a small FIFO and serializes each pair MSB-first onto
//   SD with word-select WS and a qualifying in_valid. Drives the receiver's SD/WS/in_valid directly.
//   Underrun returns the link to idle rather than sending stale data.
// PARAMETERS
//   DATA_W      32   bits per channel word (>= 2)
//   FIFO_DEPTH  2    sample-pair buffer entries (>= 1)
// PORTS
//   clk         in   1       single clock, all state on rising edge
//   rst         in   1       asynchronous, active-high reset
//   s_valid     in   1       sample pair on s_left/s_right is offered
//   s_ready     out  1       FIFO can accept; transfer when s_valid && s_ready at edge
//   s_left      in   DATA_W  left-channel sample
//   s_right     in   DATA_W  right-channel sample
//   in_valid    out  1       serial stream qualifier (high for every transmitted bit)
//   SD          out  1       serial data, MSB first
//   WS          out  1       word select: 0 = left slot, 1 = right slot (I2S, one bit early)
//   frame_done  out  1       1-cycle pulse after last right-channel bit of each pair
//   underrun    out  1       1-cycle pulse when stream stops because FIFO is empty
// BEHAVIOUR
//   Reset: FIFO emptied, state IDLE, in_valid=SD=WS=frame_done=underrun=0, s_ready=1 after reset.
//     Reset mid-frame discards the partial word and all queued pairs; no completion pulse.
//   All outputs registered. s_ready = (count < FIFO_DEPTH) from registered count; when full,
//     no push accepted in that cycle even if a pop occurs the same edge.
//   FSM: IDLE, LEFT, RIGHT; bit counter cnt runs DATA_W-1 down to 0 in each slot.
//   IDLE: if FIFO non-empty at edge -> pop, load shift regs, LEFT with cnt=DATA_W-1;
//     from that edge in_valid=1, SD=left[DATA_W-1], WS=0. A pair pushed at edge E0 into an
//     empty FIFO with FSM idle produces its MSB in the cycle after E1 (1-cycle latency).
//   LEFT: SD=left[cnt]; WS=0 except on cnt==0 where WS=1. cnt==0 -> RIGHT, cnt=DATA_W-1.
//   RIGHT: SD=right[cnt]; WS=1 except on cnt==0, where WS is decided on the edge entering
//     cnt==0: WS=0 if FIFO non-empty at that edge, else WS=1.
//   RIGHT cnt==0 exit: if WS was driven 0 -> pop next pair, LEFT, no gap (back-to-back frames);
//     frame_done=1 for the first cycle of the new left MSB.
//     else -> IDLE: in_valid=0, SD=0, WS=0, frame_done=1 and underrun=1 for one cycle.
//   A pair pushed after the WS decision edge is not used for the current continuation; it
//     starts from IDLE one cycle after the stream stops.
//   Simultaneous push and pop: count unchanged; FIFO ordering strictly first-in first-out.
//   In IDLE SD and WS are held 0 and in_valid=0; SD never toggles while in_valid=0.
//   Frame length is exactly 2*DATA_W cycles with in_valid=1 continuously inside a frame.
// TESTING
//   1 Reset: assert rst mid-stream -> all outputs 0 immediately, s_ready=1 after release.
//   2 Single pair L=32'hA5A5_0001, R=32'h8000_0003 -> 64 bits MSB-first, WS=1 on bit 31 of
//     cycle 31 (L bit0), WS=1 cycles 32-62, WS=1 cycle 63 (empty), then idle; frame_done and
//     underrun pulse together.
//   3 Three pairs pushed back-to-back -> s_ready low once 2 queued; 192 contiguous in_valid
//     cycles, WS=0 on last bit of frames 1,2; frame_done x3, underrun x1 at the end.
//   4 Push exactly on the WS decision edge of a running frame -> stream stops (underrun),
//     new frame begins from IDLE one cycle later with correct data.
//   5 Loopback into the receive stage, random 50 pairs with random s_valid gaps -> received
//     left/right words match sent pairs in order; no extra/missing words.
//   6 DATA_W=8, FIFO_DEPTH=1: pair 8'h81/8'h7E -> SD 1000_0001 0111_1110, 16 valid cycles.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: buffers stereo sample pairs in a small FIFO and shifts each pair
// out MSB-first on SD, with WS leading the slot boundary by one bit and in_valid qualifying bits.
module i2s_tx_serializer #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              in_valid,
  output logic              SD,
  output logic              WS,
  output logic              frame_done,
  output logic              underrun,
  output logic [1:0]        fsm_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  // Handshake: a pair transfers on a rising edge where s_valid && s_ready; s_ready depends only
  // on the registered occupancy, so a pop on the same edge never frees a slot for that push.
  logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [DATA_W-1:0] head_l;
  logic [DATA_W-1:0] head_r;

  state_t            state;
  logic [BIT_W-1:0]  cnt;
  logic [BIT_W-1:0]  cnt_dn;
  logic [DATA_W-1:0] cur_l;
  logic [DATA_W-1:0] cur_r;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign s_ready    = (count < CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = s_valid && s_ready;
  assign head_l     = mem_l[rd_ptr];
  assign head_r     = mem_r[rd_ptr];
  assign cnt_dn     = cnt - BIT_W'(1);
  assign fsm_state  = state;

  // WS low on the last right bit is the registered decision to continue straight into a new pair.
  assign pop = ((state == IDLE) && !fifo_empty) ||
               ((state == RIGHT) && (cnt == '0) && !WS);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= s_left;
      mem_r[wr_ptr] <= s_right;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_l      <= '0;
      cur_r      <= '0;
      in_valid   <= 1'b0;
      SD         <= 1'b0;
      WS         <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_l    <= head_l;
            cur_r    <= head_r;
            state    <= LEFT;
            cnt      <= LAST_BIT;
            in_valid <= 1'b1;
            SD       <= head_l[DATA_W-1];
            WS       <= 1'b0;
          end else begin
            in_valid <= 1'b0;
            SD       <= 1'b0;
            WS       <= 1'b0;
          end
        end
        LEFT: begin
          if (cnt == '0) begin
            state <= RIGHT;
            cnt   <= LAST_BIT;
            SD    <= cur_r[DATA_W-1];
            WS    <= 1'b1;
          end else begin
            cnt <= cnt_dn;
            SD  <= cur_l[cnt_dn];
            WS  <= (cnt == BIT_W'(1));
          end
        end
        RIGHT: begin
          if (cnt == '0) begin
            frame_done <= 1'b1;
            if (!WS) begin
              cur_l <= head_l;
              cur_r <= head_r;
              state <= LEFT;
              cnt   <= LAST_BIT;
              SD    <= head_l[DATA_W-1];
              WS    <= 1'b0;
            end else begin
              state    <= IDLE;
              in_valid <= 1'b0;
              SD       <= 1'b0;
              WS       <= 1'b0;
              underrun <= 1'b1;
            end
          end else begin
            cnt <= cnt_dn;
            SD  <= cur_r[cnt_dn];
            // Entering the last right bit: WS announces whether another pair follows.
            WS  <= (cnt == BIT_W'(1)) ? fifo_empty : 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_valid <= 1'b0;
          SD       <= 1'b0;
          WS       <= 1'b0;
        end
      endcase
    end
  end

endmodule
